// File: rtl/xled_seq_pkg.sv
// xled_seq_pkg: register map, CTRL bit positions and FSM encoding for the LED sequencer
package xled_seq_pkg;
  localparam int XLED_SEQ_PATTERN = 0;
  localparam int XLED_SEQ_LEN     = 1;
  localparam int XLED_SEQ_PERIOD  = 2;
  localparam int XLED_SEQ_CTRL    = 3;
  localparam int CTRL_START   = 0;
  localparam int CTRL_REPEAT  = 1;
  localparam int CTRL_STOP    = 2;
  localparam int CTRL_IRQ_EN  = 3;
  localparam int CTRL_IRQ_ACK = 4;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/xled_seq_timer.sv
// xled_seq_timer: loadable down-counter that pulses expire while enabled and at zero
module xled_seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] val,
  output logic             expire
);
  logic [CNT_W-1:0] cnt;
  // count down to zero and park there; a load restarts the hold
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - CNT_W'(1);
  assign expire = en && cnt == '0;
endmodule

// File: rtl/xled_seq.sv
// xled_seq: memory-mapped LED pattern sequencer; optional interrupt under XLED_SEQ_IRQ_EN
module xled_seq
  import xled_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              led,
  output logic              busy
`ifdef XLED_SEQ_IRQ_EN
  ,
  output logic              irq
`endif
);
  localparam int LW = $clog2(DATA_W) + 1;
  logic [DATA_W-1:0] pattern, sr, sr_n;
  logic [LW-1:0] len, bcnt, bcnt_n;
  logic [CNT_W-1:0] period, wper, wper_n, per1, t_val;
  state_t state, state_n;
  logic arm, arm_n, led_n, done, done_n, rpt, rpt_n, t_load, expire;
  logic wr, wctrl, start, stop;
  logic [4:0] st;
  assign wr    = sel && we;
  assign wctrl = wr && addr == ADDR_W'(XLED_SEQ_CTRL);
  assign start = wctrl && data_in[CTRL_START];
  assign stop  = wctrl && data_in[CTRL_STOP];
  assign per1  = period == '0 ? CNT_W'(1) : period;
  assign busy  = state == ST_RUN;
  // programmed registers, writable at any time; LEN saturates at DATA_W
  always_ff @(posedge clk)
    if (rst) begin
      pattern <= '0;
      len     <= '0;
      period  <= CNT_W'(1);
    end else if (wr) begin
      if (addr == ADDR_W'(XLED_SEQ_PATTERN)) pattern <= data_in;
      if (addr == ADDR_W'(XLED_SEQ_LEN)) len <= data_in > DATA_W'(DATA_W) ? LW'(DATA_W) : data_in[LW-1:0];
      if (addr == ADDR_W'(XLED_SEQ_PERIOD)) period <= data_in[CNT_W-1:0];
    end
  // state and working copies; arm marks the cycle between START and the first bit
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      arm   <= 1'b0;
      led   <= 1'b0;
      sr    <= '0;
      bcnt  <= '0;
      wper  <= '0;
      done  <= 1'b0;
      rpt   <= 1'b0;
    end else begin
      state <= state_n;
      arm   <= arm_n;
      led   <= led_n;
      sr    <= sr_n;
      bcnt  <= bcnt_n;
      wper  <= wper_n;
      done  <= done_n;
      rpt   <= rpt_n;
    end
  // next-state: load on START, shift on each hold expiry, reload or finish after the last bit
  always_comb begin
    state_n = state;
    arm_n   = arm;
    led_n   = led;
    sr_n    = sr;
    bcnt_n  = bcnt;
    wper_n  = wper;
    done_n  = done;
    t_load  = 1'b0;
    t_val   = wper - CNT_W'(1);
    rpt_n   = wctrl && !(start && (busy || arm)) ? data_in[CTRL_REPEAT] : rpt;
    if (state == ST_IDLE && arm) begin
      arm_n   = 1'b0;
      state_n = bcnt == '0 ? ST_IDLE : ST_RUN;
      led_n   = bcnt != '0 && sr[0];
      done_n  = bcnt == '0;
      t_load  = bcnt != '0;
    end else if (state == ST_IDLE && start) begin
      arm_n  = 1'b1;
      sr_n   = pattern;
      bcnt_n = len;
      wper_n = per1;
      done_n = 1'b0;
    end else if (state == ST_RUN && expire) begin
      if (bcnt > LW'(1)) begin
        sr_n   = sr >> 1;
        led_n  = sr[1];
        bcnt_n = bcnt - LW'(1);
        t_load = 1'b1;
      end else if (rpt && len != '0) begin
        sr_n   = pattern;
        bcnt_n = len;
        wper_n = per1;
        led_n  = pattern[0];
        t_load = 1'b1;
        t_val  = per1 - CNT_W'(1);
      end else begin
        state_n = ST_IDLE;
        led_n   = 1'b0;
        done_n  = 1'b1;
      end
    end
    if (stop) begin
      state_n = ST_IDLE;
      arm_n   = 1'b0;
      led_n   = 1'b0;
      done_n  = done;
      t_load  = 1'b0;
    end
  end
  xled_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (busy),
    .load   (t_load),
    .val    (t_val),
    .expire (expire)
  );
`ifdef XLED_SEQ_IRQ_EN
  logic irq_en, pass_end;
  assign pass_end = busy && expire && bcnt <= LW'(1) && !stop;
  // sticky interrupt: set at each pass end when enabled, set wins over a same-cycle ACK
  always_ff @(posedge clk)
    if (rst) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wctrl) irq_en <= data_in[CTRL_IRQ_EN];
      irq <= (irq_en && pass_end) || (irq && !(wctrl && data_in[CTRL_IRQ_ACK]));
    end
  assign st = {1'b0, irq_en, rpt, done, busy};
`else
  assign st = {2'b0, rpt, done, busy};
`endif
  // combinational register readback
  always_comb
    data_out = addr == ADDR_W'(XLED_SEQ_PATTERN) ? pattern :
               addr == ADDR_W'(XLED_SEQ_LEN)     ? DATA_W'(len) :
               addr == ADDR_W'(XLED_SEQ_PERIOD)  ? DATA_W'(period) : DATA_W'(st);
endmodule

// File: tb/tb_xled_seq.sv
// tb_xled_seq: directed self-checking bench for xled_seq (IRQ checks when XLED_SEQ_IRQ_EN is defined)
module tb_xled_seq;
  logic clk = 1'b0, rst = 1'b1, sel = 1'b0, we = 1'b0, led, busy;
  logic [1:0] addr = '0;
  logic [31:0] data_in = '0, data_out, v;
`ifdef XLED_SEQ_IRQ_EN
  logic irq;
`endif
  int total = 0, bad = 0;
  always #10 clk = ~clk;
  xled_seq dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .led(led), .busy(busy)
`ifdef XLED_SEQ_IRQ_EN
    , .irq(irq)
`endif
  );
  task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = w; we = w; addr = a; data_in = d;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] r);
    addr = a;
    #1;
    r = data_out;
  endtask
  task automatic test_reset;
    logic [31:0] want [4] = '{32'd0, 32'd0, 32'd1, 32'd0};
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 1'b0;
    total++; if (led !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_out led=%b busy=%b want 0 0", led, busy); end
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      total++; if (v !== want[i]) begin bad++; $display("FAIL reset_reg[%0d] got=%0h want=%0h", i, v, want[i]); end
    end
  endtask
  task automatic test_oneshot;
    logic [11:0] e = 12'b111000111111;
    step(1, 0, 32'hB); step(1, 1, 4); step(1, 2, 3); step(1, 3, 1);
    total++; if (led !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL oneshot_arm led=%b busy=%b want 0 0", led, busy); end
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0);
      total++; if (led !== e[i] || busy !== 1'b1) begin bad++; $display("FAIL oneshot[%0d] led=%b busy=%b want %b 1", i, led, busy, e[i]); end
    end
    step(0, 0, 0);
    rd(3, v);
    total++; if (led !== 1'b0 || busy !== 1'b0 || v !== 32'd2) begin bad++; $display("FAIL oneshot_end led=%b busy=%b st=%0h want 0 0 2", led, busy, v); end
  endtask
  task automatic test_repeat;
    logic [11:0] e = 12'b111000111111;
    step(1, 3, 3);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL repeat_arm busy=%b want 0", busy); end
    for (int i = 0; i < 12; i++) begin
      step(i == 4, 0, 1);
      total++; if (led !== e[i] || busy !== 1'b1) begin bad++; $display("FAIL repeat_p1[%0d] led=%b busy=%b want %b 1", i, led, busy, e[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0);
      total++; if (led !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL repeat_p2[%0d] led=%b busy=%b want 1 1", i, led, busy); end
    end
    step(1, 3, 4);
    rd(3, v);
    total++; if (led !== 1'b0 || busy !== 1'b0 || v !== 32'd0) begin bad++; $display("FAIL repeat_stop led=%b busy=%b st=%0h want 0 0 0", led, busy, v); end
    rd(0, v);
    total++; if (v !== 32'd1) begin bad++; $display("FAIL repeat_pat got=%0h want 1", v); end
  endtask
  task automatic test_len0;
    step(1, 1, 0); step(1, 3, 1);
    rd(3, v);
    total++; if (busy !== 1'b0 || v !== 32'd0) begin bad++; $display("FAIL len0_a busy=%b st=%0h want 0 0", busy, v); end
    step(0, 0, 0);
    rd(3, v);
    total++; if (busy !== 1'b0 || v !== 32'd2) begin bad++; $display("FAIL len0_b busy=%b st=%0h want 0 2", busy, v); end
  endtask
  task automatic test_period0;
    logic [2:0] el = 3'b010, eb = 3'b011;
    step(1, 0, 2); step(1, 1, 2); step(1, 2, 0);
    rd(2, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL period0_rd got=%0h want 0", v); end
    step(1, 3, 1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL period0_arm busy=%b want 0", busy); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      total++; if (led !== el[i] || busy !== eb[i]) begin bad++; $display("FAIL period0[%0d] led=%b busy=%b want %b %b", i, led, busy, el[i], eb[i]); end
    end
  endtask
  task automatic test_start_stop;
    step(1, 3, 5);
    total++; if (busy !== 1'b0 || led !== 1'b0) begin bad++; $display("FAIL ss_a busy=%b led=%b want 0 0", busy, led); end
    step(0, 0, 0);
    rd(3, v);
    total++; if (busy !== 1'b0 || led !== 1'b0 || v !== 32'd2) begin bad++; $display("FAIL ss_b busy=%b led=%b st=%0h want 0 0 2", busy, led, v); end
  endtask
  task automatic test_len_sat;
    step(1, 1, 40);
    rd(1, v);
    total++; if (v !== 32'd32) begin bad++; $display("FAIL len_sat40 got=%0d want 32", v); end
    step(1, 1, 32);
    rd(1, v);
    total++; if (v !== 32'd32) begin bad++; $display("FAIL len_32 got=%0d want 32", v); end
  endtask
  task automatic test_reset_midrun;
    step(1, 0, 32'hB); step(1, 1, 4); step(1, 2, 3); step(1, 3, 3);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    total++; if (busy !== 1'b1 || led !== 1'b1) begin bad++; $display("FAIL midrun_pre busy=%b led=%b want 1 1", busy, led); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || led !== 1'b0) begin bad++; $display("FAIL midrun_rst busy=%b led=%b want 0 0", busy, led); end
    rd(0, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL midrun_pat got=%0h want 0", v); end
    rd(2, v);
    total++; if (v !== 32'd1) begin bad++; $display("FAIL midrun_per got=%0h want 1", v); end
    rd(3, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL midrun_st got=%0h want 0", v); end
    rst = 1'b0;
  endtask
`ifdef XLED_SEQ_IRQ_EN
  task automatic test_irq;
    logic [3:0] ei = 4'b1100;
    step(1, 0, 3); step(1, 1, 2); step(1, 2, 0); step(1, 3, 9);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0);
      total++; if (irq !== ei[i]) begin bad++; $display("FAIL irq_oneshot[%0d] irq=%b want %b", i, irq, ei[i]); end
    end
    step(1, 3, 24);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_ack irq=%b want 0", irq); end
    step(1, 1, 1); step(1, 3, 11); step(0, 0, 0);
    total++; if (irq !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL irq_rep_a irq=%b busy=%b want 0 1", irq, busy); end
    step(0, 0, 0);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_wrap irq=%b want 1", irq); end
    step(1, 3, 26);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_ack_wrap irq=%b want 1", irq); end
    step(1, 3, 12);
    total++; if (irq !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL irq_stop irq=%b busy=%b want 1 0", irq, busy); end
    step(1, 3, 24);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_ack2 irq=%b want 0", irq); end
  endtask
`endif
  initial begin
    test_reset;
    test_oneshot;
    test_repeat;
    test_len0;
    test_period0;
    test_start_stop;
    test_len_sat;
    test_reset_midrun;
`ifdef XLED_SEQ_IRQ_EN
    test_irq;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
